// File: rtl/tr5_timer_driver.sv
// rtl/tr5_timer_driver.sv - Avalon-MM initiator that programs, runs and services the interval timer
// Optional snapshot readback is built when TIMER_DRIVER_SNAPSHOT_EN is defined.
module tr5_timer_driver #(
    parameter int TICK_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic              snap_req,
    output logic              busy,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic [31:0]       snap_value,
    output logic              snap_valid,
    output logic              err,
    output logic [2:0]        av_address,
    output logic              av_chipselect,
    output logic              av_write_n,
    output logic [15:0]       av_writedata,
    input  logic [15:0]       av_readdata,
    input  logic              irq
);
    localparam logic [2:0]  A_STATUS   = 3'd0;
    localparam logic [2:0]  A_CONTROL  = 3'd1;
    localparam logic [2:0]  A_PERIOD_L = 3'd2;
    localparam logic [2:0]  A_PERIOD_H = 3'd3;
    localparam logic [2:0]  A_SNAP_L   = 3'd4;
    localparam logic [2:0]  A_SNAP_H   = 3'd5;
    localparam logic [15:0] CTRL_RUN   = 16'h0007;
    localparam logic [15:0] CTRL_STOP  = 16'h0008;
    localparam logic [31:0] MIN_PERIOD = 32'd8;

    typedef enum logic [3:0] {
        IDLE,
        WR_PL,
        WR_PH,
        WR_CTRL,
        RUN,
        CLR_ST,
        WR_STOP
`ifdef TIMER_DRIVER_SNAPSHOT_EN
        ,
        SNAP_WR,
        SNAP_RL,
        SNAP_RH,
        SNAP_CAP
`endif
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] period_hi;
    logic        start_ok;
    logic [2:0]  addr_nxt;
    logic [15:0] wdata_nxt;
    logic        cs_nxt;
    logic        wn_nxt;

    assign start_ok = cfg_start && (cfg_period >= MIN_PERIOD);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = WR_PL;
            WR_PL:   state_nxt = WR_PH;
            WR_PH:   state_nxt = WR_CTRL;
            WR_CTRL: state_nxt = RUN;
            RUN: begin
                // A timeout always wins so no tick is ever lost to a stop or snapshot.
                if (irq) begin
                    state_nxt = CLR_ST;
                end else if (cfg_stop) begin
                    state_nxt = WR_STOP;
                end
`ifdef TIMER_DRIVER_SNAPSHOT_EN
                else if (snap_req) begin
                    state_nxt = SNAP_WR;
                end
`endif
            end
            CLR_ST:  state_nxt = RUN;
            WR_STOP: state_nxt = IDLE;
`ifdef TIMER_DRIVER_SNAPSHOT_EN
            SNAP_WR:  state_nxt = SNAP_RL;
            SNAP_RL:  state_nxt = SNAP_RH;
            SNAP_RH:  state_nxt = SNAP_CAP;
            SNAP_CAP: state_nxt = RUN;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Bus signals are decoded from the state being entered so they register alongside it.
    always_comb begin
        addr_nxt  = av_address;
        wdata_nxt = av_writedata;
        cs_nxt    = 1'b0;
        wn_nxt    = 1'b1;
        case (state_nxt)
            WR_PL: begin
                addr_nxt  = A_PERIOD_L;
                wdata_nxt = cfg_period[15:0];
                cs_nxt    = 1'b1;
                wn_nxt    = 1'b0;
            end
            WR_PH: begin
                addr_nxt  = A_PERIOD_H;
                wdata_nxt = period_hi;
                cs_nxt    = 1'b1;
                wn_nxt    = 1'b0;
            end
            WR_CTRL: begin
                addr_nxt  = A_CONTROL;
                wdata_nxt = CTRL_RUN;
                cs_nxt    = 1'b1;
                wn_nxt    = 1'b0;
            end
            CLR_ST: begin
                addr_nxt  = A_STATUS;
                wdata_nxt = 16'h0000;
                cs_nxt    = 1'b1;
                wn_nxt    = 1'b0;
            end
            WR_STOP: begin
                addr_nxt  = A_CONTROL;
                wdata_nxt = CTRL_STOP;
                cs_nxt    = 1'b1;
                wn_nxt    = 1'b0;
            end
`ifdef TIMER_DRIVER_SNAPSHOT_EN
            SNAP_WR: begin
                addr_nxt  = A_SNAP_L;
                wdata_nxt = 16'h0000;
                cs_nxt    = 1'b1;
                wn_nxt    = 1'b0;
            end
            SNAP_RL: begin
                addr_nxt = A_SNAP_L;
                cs_nxt   = 1'b1;
            end
            SNAP_RH: begin
                addr_nxt = A_SNAP_H;
                cs_nxt   = 1'b1;
            end
`endif
            default: begin
                cs_nxt = 1'b0;
            end
        endcase
    end

`ifdef TIMER_DRIVER_SNAPSHOT_EN
    logic [15:0] snap_lo;
`else
    logic unused_snap;
    assign unused_snap = ^{av_readdata, snap_req};
    assign snap_value  = 32'h0000_0000;
    assign snap_valid  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            period_hi     <= 16'h0000;
            busy          <= 1'b0;
            tick          <= 1'b0;
            tick_count    <= '0;
            err           <= 1'b0;
            av_address    <= 3'd0;
            av_chipselect <= 1'b0;
            av_write_n    <= 1'b1;
            av_writedata  <= 16'h0000;
`ifdef TIMER_DRIVER_SNAPSHOT_EN
            snap_lo       <= 16'h0000;
            snap_value    <= 32'h0000_0000;
            snap_valid    <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            busy          <= (state_nxt != IDLE);
            tick          <= (state_nxt == CLR_ST);
            err           <= (state == IDLE) && cfg_start && !start_ok;
            av_address    <= addr_nxt;
            av_chipselect <= cs_nxt;
            av_write_n    <= wn_nxt;
            av_writedata  <= wdata_nxt;
            if ((state == IDLE) && start_ok) begin
                period_hi  <= cfg_period[31:16];
                tick_count <= '0;
            end else if (state_nxt == CLR_ST) begin
                tick_count <= tick_count + TICK_W'(1);
            end
`ifdef TIMER_DRIVER_SNAPSHOT_EN
            // Slave readdata lags the address by one cycle, hence the RH/CAP sampling points.
            snap_valid <= (state == SNAP_CAP);
            if (state == SNAP_RH) snap_lo <= av_readdata;
            if (state == SNAP_CAP) snap_value <= {av_readdata, snap_lo};
`endif
        end
    end
endmodule

// File: tb/tb_tr5_timer_driver.sv
// tb/tb_tr5_timer_driver.sv - randomized self-checking bench for tr5_timer_driver with an interval-timer slave model
module tb_tr5_timer_driver;
    logic        clk;
    logic        reset_n;
    logic [31:0] cfg_period;
    logic        cfg_start;
    logic        cfg_stop;
    logic        snap_req;
    logic        busy;
    logic        tick;
    logic [31:0] tick_count;
    logic [31:0] snap_value;
    logic        snap_valid;
    logic        err;
    logic [2:0]  av_address;
    logic        av_chipselect;
    logic        av_write_n;
    logic [15:0] av_writedata;
    logic [15:0] av_readdata;
    logic        irq;

    int vectors;
    int miscompares;
    int cyc;

    tr5_timer_driver #(.TICK_W(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cfg_period   (cfg_period),
        .cfg_start    (cfg_start),
        .cfg_stop     (cfg_stop),
        .snap_req     (snap_req),
        .busy         (busy),
        .tick         (tick),
        .tick_count   (tick_count),
        .snap_value   (snap_value),
        .snap_valid   (snap_valid),
        .err          (err),
        .av_address   (av_address),
        .av_chipselect(av_chipselect),
        .av_write_n   (av_write_n),
        .av_writedata (av_writedata),
        .av_readdata  (av_readdata),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Interval-timer slave: counts period..0 inclusive, so a timeout every period+1 cycles.
    logic [31:0] s_period, s_count, s_snap;
    logic        s_run, s_to, s_ito;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_period    <= 32'd0;
            s_count     <= 32'd0;
            s_snap      <= 32'd0;
            s_run       <= 1'b0;
            s_to        <= 1'b0;
            s_ito       <= 1'b0;
            av_readdata <= 16'h0000;
        end else begin
            if (s_run) begin
                if (s_count == 32'd0) begin
                    s_to    <= 1'b1;
                    s_count <= s_period;
                end else begin
                    s_count <= s_count - 32'd1;
                end
            end
            if (av_chipselect && !av_write_n) begin
                case (av_address)
                    3'd0: s_to <= 1'b0;
                    3'd1: begin
                        s_ito <= av_writedata[0];
                        if (av_writedata[3]) s_run <= 1'b0;
                        else if (av_writedata[2]) begin
                            s_run   <= 1'b1;
                            s_count <= s_period;
                        end
                    end
                    3'd2: s_period[15:0]  <= av_writedata;
                    3'd3: s_period[31:16] <= av_writedata;
                    3'd4: s_snap <= s_count;
                    default: ;
                endcase
            end
            if (av_address == 3'd4)      av_readdata <= s_snap[15:0];
            else if (av_address == 3'd5) av_readdata <= s_snap[31:16];
            else                         av_readdata <= 16'h0000;
        end
    end
    assign irq = s_to & s_ito;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues a start and checks the three programming writes in consecutive cycles.
    task automatic start_prog(input logic [31:0] p, output int t0);
        t0 = cyc;
        cfg_period = p;
        cfg_start  = 1'b1;
        step();
        cfg_start  = 1'b0;
        cfg_period = $urandom;
        vectors++;
        if ({av_chipselect, av_write_n, av_address, av_writedata} !== {1'b1, 1'b0, 3'd2, p[15:0]}) begin
            miscompares++;
            $display("FAIL prog_pl: got cs=%b wn=%b %0d:%h want 2:%h", av_chipselect, av_write_n, av_address, av_writedata, p[15:0]);
        end
        step();
        vectors++;
        if ({av_chipselect, av_write_n, av_address, av_writedata} !== {1'b1, 1'b0, 3'd3, p[31:16]}) begin
            miscompares++;
            $display("FAIL prog_ph: got cs=%b wn=%b %0d:%h want 3:%h", av_chipselect, av_write_n, av_address, av_writedata, p[31:16]);
        end
        step();
        vectors++;
        if ({av_chipselect, av_write_n, av_address, av_writedata} !== {1'b1, 1'b0, 3'd1, 16'h0007}) begin
            miscompares++;
            $display("FAIL prog_ctrl: got cs=%b wn=%b %0d:%h want 1:0007", av_chipselect, av_write_n, av_address, av_writedata);
        end
        step();
        vectors++;
        if (av_chipselect !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL prog_run: got cs=%b busy=%b want cs=0 busy=1", av_chipselect, busy);
        end
    endtask

    task automatic wait_tick(input int budget, output int at, output bit ok);
        ok = 1'b0;
        at = cyc;
        for (int i = 0; i < budget; i++) begin
            step();
            if (tick === 1'b1) begin
                ok = 1'b1;
                at = cyc;
                return;
            end
        end
    endtask

    // Raises cfg_stop for one cycle; caller guarantees the DUT is in RUN with irq low.
    task automatic do_stop();
        cfg_stop = 1'b1;
        step();
        cfg_stop = 1'b0;
        vectors++;
        if ({av_chipselect, av_write_n, av_address, av_writedata} !== {1'b1, 1'b0, 3'd1, 16'h0008}) begin
            miscompares++;
            $display("FAIL stop_write: got cs=%b wn=%b %0d:%h want 1:0008", av_chipselect, av_write_n, av_address, av_writedata);
        end
        step();
        vectors++;
        if (busy !== 1'b0 || av_chipselect !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_idle: got busy=%b cs=%b want 0 0", busy, av_chipselect);
        end
    endtask

    // Checks first-tick latency (P+6 from the start cycle) and later spacing (P+1).
    task automatic run_ticks(input string name, input logic [31:0] p, input int t0, input int n);
        int  last, at, want;
        bit  ok;
        last = t0;
        for (int k = 1; k <= n; k++) begin
            wait_tick(int'(p) + 20, at, ok);
            want = (k == 1) ? int'(p) + 6 : int'(p) + 1;
            vectors++;
            if (!ok || (at - last) != want) begin
                miscompares++;
                $display("FAIL %s_interval%0d: got %0d cycles (seen=%0d) want %0d", name, k, at - last, ok, want);
            end
            vectors++;
            if (tick_count !== 32'(k)) begin
                miscompares++;
                $display("FAIL %s_count%0d: got %0d want %0d", name, k, tick_count, k);
            end
            last = at;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        vectors++;
        if ({busy, tick, err, snap_valid, av_chipselect, av_write_n} !== 6'b000001 ||
            tick_count !== 32'd0 || snap_value !== 32'd0 || av_address !== 3'd0 || av_writedata !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_values: got busy=%b tick=%b err=%b sv=%b cs=%b wn=%b cnt=%0d snap=%h a=%0d wd=%h want all zero, wn=1",
                     busy, tick, err, snap_valid, av_chipselect, av_write_n, tick_count, snap_value, av_address, av_writedata);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int t0;
        start_prog(32'd49, t0);
        run_ticks("basic", 32'd49, t0, 3);
        step();
        do_stop();
    endtask

    task automatic test_err();
        logic [31:0] p;
        for (int i = 0; i < 4; i++) begin
            p = (i == 0) ? 32'd5 : ((i == 1) ? 32'd7 : 32'($urandom_range(0, 7)));
            cfg_period = p;
            cfg_start  = 1'b1;
            step();
            cfg_start  = 1'b0;
            vectors++;
            if (err !== 1'b1 || av_chipselect !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL err_pulse p=%0d: got err=%b cs=%b busy=%b want 1 0 0", p, err, av_chipselect, busy);
            end
            step();
            vectors++;
            if (err !== 1'b0 || busy !== 1'b0 || av_chipselect !== 1'b0) begin
                miscompares++;
                $display("FAIL err_after p=%0d: got err=%b busy=%b cs=%b want 0 0 0", p, err, busy, av_chipselect);
            end
        end
    endtask

    task automatic test_random_periods();
        logic [31:0] p;
        int t0;
        for (int i = 0; i < 4; i++) begin
            p = (i == 0) ? 32'd8 : 32'($urandom_range(9, 120));
            start_prog(p, t0);
            run_ticks("rand", p, t0, $urandom_range(2, 4));
            step();
            do_stop();
        end
    endtask

    task automatic test_stop_after_ten();
        logic [31:0] p;
        int  t0;
        bit  seen;
        p = 32'($urandom_range(8, 30));
        start_prog(p, t0);
        run_ticks("ten", p, t0, 10);
        step();
        do_stop();
        seen = 1'b0;
        for (int i = 0; i < 3 * (int'(p) + 1) + 10; i++) begin
            step();
            if (irq !== 1'b0 || tick !== 1'b0 || av_chipselect !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        vectors++;
        if (seen || tick_count !== 32'd10) begin
            miscompares++;
            $display("FAIL ten_quiet: got activity=%b count=%0d want 0 10", seen, tick_count);
        end
    endtask

    task automatic test_irq_stop_collision();
        int t0;
        bit ok;
        start_prog(32'd20, t0);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            if (irq === 1'b1) ok = 1'b1;
        end
        cfg_stop = 1'b1;
        step();
        cfg_stop = 1'b0;
        vectors++;
        if (!ok || {av_chipselect, av_write_n, av_address} !== {1'b1, 1'b0, 3'd0} || tick !== 1'b1 || tick_count !== 32'd1) begin
            miscompares++;
            $display("FAIL coll_clear: got irq_seen=%b cs=%b wn=%b a=%0d tick=%b cnt=%0d want 1 1 0 0 1 1",
                     ok, av_chipselect, av_write_n, av_address, tick, tick_count);
        end
        step();
        step();
        step();
        vectors++;
        if (busy !== 1'b1 || av_chipselect !== 1'b0) begin
            miscompares++;
            $display("FAIL coll_dropped: got busy=%b cs=%b want 1 0", busy, av_chipselect);
        end
        do_stop();
        vectors++;
        if (tick_count !== 32'd1) begin
            miscompares++;
            $display("FAIL coll_count: got %0d want 1", tick_count);
        end
    endtask

    task automatic test_snapshot();
        int t0;
        int r;
        logic [31:0] p;
        p = 32'h0001_0000;
        start_prog(p, t0);
        step();
        step();
        step();
        // A start while running must be ignored without flagging an error.
        cfg_period = 32'd3;
        cfg_start  = 1'b1;
        step();
        cfg_start  = 1'b0;
        vectors++;
        if (err !== 1'b0 || av_chipselect !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL run_start_ignored: got err=%b cs=%b busy=%b want 0 0 1", err, av_chipselect, busy);
        end
        r = cyc;
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
`ifdef TIMER_DRIVER_SNAPSHOT_EN
        vectors++;
        if ({av_chipselect, av_write_n, av_address} !== {1'b1, 1'b0, 3'd4}) begin
            miscompares++;
            $display("FAIL snap_wr: got cs=%b wn=%b a=%0d want 1 0 4", av_chipselect, av_write_n, av_address);
        end
        step();
        vectors++;
        if ({av_chipselect, av_write_n, av_address} !== {1'b1, 1'b1, 3'd4}) begin
            miscompares++;
            $display("FAIL snap_rl: got cs=%b wn=%b a=%0d want 1 1 4", av_chipselect, av_write_n, av_address);
        end
        step();
        vectors++;
        if ({av_chipselect, av_write_n, av_address} !== {1'b1, 1'b1, 3'd5}) begin
            miscompares++;
            $display("FAIL snap_rh: got cs=%b wn=%b a=%0d want 1 1 5", av_chipselect, av_write_n, av_address);
        end
        step();
        step();
        // Counter latched at end of the cycle after the request: P - (r + 1 - (t0 + 4)).
        vectors++;
        if (snap_valid !== 1'b1 || snap_value !== p - 32'(r - t0 - 3) || snap_value > p) begin
            miscompares++;
            $display("FAIL snap_value: got valid=%b value=%h want 1 %h", snap_valid, snap_value, p - 32'(r - t0 - 3));
        end
        do_stop();
        vectors++;
        if (snap_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL snap_pulse: got valid=%b want 0", snap_valid);
        end
`else
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (snap_valid !== 1'b0 || av_chipselect !== 1'b0 || snap_value !== 32'd0) seen = 1'b1;
                step();
            end
            vectors++;
            if (seen || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL snap_disabled: got activity=%b busy=%b want 0 1", seen, busy);
            end
            do_stop();
        end
`endif
    endtask

    task automatic test_reset_mid();
        int t0;
        logic [31:0] p;
        cfg_period = 32'h0002_1234;
        cfg_start  = 1'b1;
        step();
        cfg_start  = 1'b0;
        step();
        vectors++;
        if (av_address !== 3'd3 || av_chipselect !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_wr_ph: got a=%0d cs=%b want 3 1", av_address, av_chipselect);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({busy, tick, av_chipselect, av_write_n} !== 4'b0001 || av_address !== 3'd0 ||
            av_writedata !== 16'h0 || tick_count !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_reset: got busy=%b tick=%b cs=%b wn=%b a=%0d wd=%h cnt=%0d want 0 0 0 1 0 0 0",
                     busy, tick, av_chipselect, av_write_n, av_address, av_writedata, tick_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        p = 32'($urandom_range(8, 60));
        start_prog(p, t0);
        run_ticks("after_rst", p, t0, 2);
        step();
        do_stop();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        reset_n     = 1'b0;
        cfg_period  = 32'd0;
        cfg_start   = 1'b0;
        cfg_stop    = 1'b0;
        snap_req    = 1'b0;
        test_reset();
        test_basic();
        test_err();
        test_random_periods();
        test_stop_after_ten();
        test_irq_stop_collision();
        test_snapshot();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
